servant_uart_tx_arb: RTL and testbench
======================================

# servant_uart_tx_arb

Shares the single board UART TX pin between the SoC's bit-banged GPIO output `q` and a hardware byte source (boot/status reporter) that has no CPU involvement. Sits between the `servant` instance and `o_uart_tx` in the board top, in the `wb_clk` domain. The block passes the SoC line straight through by default. It serializes a hardware byte (8N1) only after the SoC line has been idle long enough that no SoC character can be in flight.

## Interface
- `BAUD_DIV`, 139, clock cycles per UART bit (≥2)
- `IDLE_BITS`, 12, bit-times of continuous SoC-idle (high) required before a hardware frame may start (≥1)
- `wb_clk` input 1 system clock; all logic on rising edge
- `wb_rst_n` input 1 reset; one clock; reset is asynchronous and active-low
- `i_q` input 1 SoC bit-banged TX level, synchronous to `wb_clk` (no synchronizer)
- `i_data` input 8 hardware byte
- `i_valid` input 1 hardware byte offered; must hold `i_data` stable until accepted
- `o_ready` output 1 one-cycle accept strobe; byte transfers when `i_valid && o_ready`
- `o_tx` output 1 registered line to pin
- `o_owner` output 1 0 = SoC owns line, 1 = hardware frame in progress
- `o_collision` output 1 one-cycle pulse: SoC line fell while hardware owned the pin

## Operation
- States: PASS, START, DATA, STOP.
- **PASS:** `o_tx <= i_q`, `o_owner = 0`.
- **Idle counter** (width `$clog2(IDLE_BITS+1)`, saturating at `IDLE_BITS`):
  - Cleared on any cycle with `i_q == 0`.
  - Counts one per completed bit-time while `i_q == 1`, in every state.
  - Bit-time is timed by a free-running sub-counter 0..`BAUD_DIV-1`, also cleared when `i_q == 0`.
- **PASS → START:** when `i_valid && idle == IDLE_BITS && i_q == 1`.
  - Same cycle: `o_ready = 1`, byte latched into shift register, baud counter cleared.
- **START:** `o_tx = 0` for `BAUD_DIV` cycles, then → DATA.
- **DATA:** 8 bits LSB first, `BAUD_DIV` cycles each.
  - 3-bit index; after bit 7 → STOP.
- **STOP:** `o_tx = 1` for `BAUD_DIV` cycles, then → PASS.
  - Idle counter is not reset by frame completion, so back-to-back hardware bytes run with no gap while the SoC stays idle.
- **Collision:**
  - Any falling edge of `i_q` (registered previous value 1, current 0) while state ≠ PASS pulses `o_collision` for one cycle.
  - SoC data during the frame is dropped. The hardware frame always completes; the SoC is never stalled.
- **Return to PASS mid SoC character:** `o_tx` follows `i_q` immediately. The corrupted character is already flagged by `o_collision`.
- **Asserted `wb_rst_n` (low):**
  - State PASS, `o_tx = 1`, `o_owner = 0`, `o_ready = 0`, `o_collision = 0`.
  - Idle, baud and bit counters 0; edge register 1.
  - A frame cut by reset is abandoned, not resumed. The line returns high immediately.

## Timing
- SoC pass-through latency: 1 cycle (`i_q` → `o_tx`).
- `o_ready` is combinational from state, counters, `i_valid` and `i_q`; asserted at most once per frame.
- Frame start:
  - `o_tx` goes low and `o_owner` goes high the cycle after acceptance.
  - Frame lasts exactly `10*BAUD_DIV` cycles; `o_owner` returns 0 on the following edge.
- Earliest acceptance after `i_q` rises: `IDLE_BITS*BAUD_DIV` cycles later.
- Next back-to-back acceptance: first PASS cycle after STOP ends.
- `o_collision`: the cycle after the falling edge is sampled (registered).
- Simultaneous `i_valid` arrival and `i_q` fall: `i_q == 0` blocks acceptance that cycle.

## Structure
- Package `servant_uart_pkg`:
  - State enum `uart_arb_state_t`.
  - Constants `UART_DATA_BITS = 8` and `UART_FRAME_BITS = 10`.
- Sub-module `servant_uart_baud`: baud sub-counter with clear input and a bit-time tick output. It is instantiated once and reused for both idle timing and frame timing.
- Remaining logic (FSM, shift register, idle counter, collision detect) stays in the top.

## Test plan
Bench parameters: `BAUD_DIV = 4`, `IDLE_BITS = 2`.
1. **Reset:** `wb_rst_n` low mid-DATA → next cycle `o_tx = 1`, `o_owner = 0`, `o_ready = 0`. After release, `i_q = 1` plus `i_valid` → acceptance exactly 8 cycles later.
2. **Pass-through:** toggle `i_q` 1,0,0,1 with no `i_valid` → `o_tx` equals the same sequence delayed 1 cycle; `o_owner` stays 0.
3. **Single frame:** `i_data = 0xA5` after 8 idle cycles → `o_tx` = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles (40 total). `o_ready` high exactly once.
4. **Back-to-back:** `i_valid` held with `0x00` then `0xFF`, `i_q = 1` → second start bit begins on the cycle after the first stop bit ends; no idle gap.
5. **Idle guard:** `i_q` low 1 cycle every 6 cycles with `i_valid` high → `o_ready` never asserts. Stop the pulses → acceptance 8 cycles after the last rise.
6. **Collision:** `i_q` falls 12 cycles into a frame → single-cycle `o_collision`. `o_tx` keeps the frame bits; the frame completes at 40 cycles; `o_tx` then equals delayed `i_q`.

Source files
------------

// File: rtl/servant_uart_pkg.sv
`default_nettype none
// ============================================================================
// servant_uart_pkg : shared types and constants for the UART TX arbiter
// Revision: 1.0
// ============================================================================
package servant_uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/servant_uart_baud.sv
`default_nettype none
// ============================================================================
// servant_uart_baud : free-running bit-time counter with clear and tick output
// Revision: 1.0
// ============================================================================
module servant_uart_baud #(
  parameter int BAUD_DIV = 139
) (
  input  logic wb_clk,
  input  logic wb_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int            c_CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(BAUD_DIV - 1);

  logic [c_CW-1:0] r_cnt;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = !i_clear && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/servant_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// servant_uart_tx_arb : shares the UART TX pin between SoC GPIO and a HW byte
// Revision: 1.0
// ============================================================================
module servant_uart_tx_arb
  import servant_uart_pkg::*;
#(
  parameter int BAUD_DIV  = 139,
  parameter int IDLE_BITS = 12
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic       i_q,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_owner,
  output logic       o_collision
);

  localparam int               c_IW       = $clog2(IDLE_BITS + 1);
  localparam logic [c_IW-1:0]  c_IDLE_MAX = c_IW'(IDLE_BITS);
  localparam logic [2:0]       c_BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_arb_state_t r_state, w_state_next;
  logic [7:0]      r_shift, w_shift_next;
  logic [2:0]      r_bit, w_bit_next;
  logic [c_IW-1:0] r_idle;
  logic            r_q_prev;
  logic            r_tx;
  logic            r_coll;
  logic            w_tx_d;
  logic            w_accept;
  logic            w_baud_clr;
  logic            w_tick;

  assign w_accept = (r_state == ST_PASS) && i_valid && i_q && (r_idle == c_IDLE_MAX);

  // During a frame the baud counter times the frame, so SoC activity must not disturb it
  assign w_baud_clr = ((r_state == ST_PASS) && !i_q) || w_accept;

  servant_uart_baud #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .i_clear  (w_baud_clr),
    .o_tick   (w_tick)
  );

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state  <= ST_PASS;
      r_shift  <= '0;
      r_bit    <= '0;
      r_idle   <= '0;
      r_q_prev <= 1'b1;
      r_tx     <= 1'b1;
      r_coll   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_shift  <= w_shift_next;
      r_bit    <= w_bit_next;
      r_q_prev <= i_q;
      r_tx     <= w_tx_d;
      r_coll   <= r_q_prev && !i_q && (r_state != ST_PASS);
      if (!i_q) begin
        r_idle <= '0;
      end else if (w_tick && (r_idle != c_IDLE_MAX)) begin
        r_idle <= r_idle + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit;
    case (r_state)
      ST_PASS: begin
        if (w_accept) begin
          w_state_next = ST_START;
          w_shift_next = i_data;
          w_bit_next   = '0;
        end
      end
      ST_START: begin
        if (w_tick) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit == c_BIT_LAST) begin
            w_state_next = ST_STOP;
          end else begin
            w_bit_next   = r_bit + 1'b1;
            w_shift_next = {1'b0, r_shift[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (w_tick) w_state_next = ST_PASS;
      end
      default: w_state_next = ST_PASS;
    endcase
  end

  // Line level is registered from the next state so frame bits appear the cycle after each transition
  always_comb begin
    w_tx_d = 1'b1;
    case (w_state_next)
      ST_PASS:  w_tx_d = i_q;
      ST_START: w_tx_d = 1'b0;
      ST_DATA:  w_tx_d = w_shift_next[0];
      ST_STOP:  w_tx_d = 1'b1;
      default:  w_tx_d = 1'b1;
    endcase
  end

  assign o_ready     = w_accept;
  assign o_tx        = r_tx;
  assign o_owner     = (r_state != ST_PASS);
  assign o_collision = r_coll;

endmodule
`default_nettype wire

// File: tb/tb_servant_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// tb_servant_uart_tx_arb : scoreboard bench for the UART TX arbiter
// Revision: 1.0
// ============================================================================
module tb_servant_uart_tx_arb;

  localparam int c_BAUD = 4;
  localparam int c_IDLE = 2;
  localparam int c_WAIT = c_BAUD * c_IDLE;
  localparam int c_FLEN = 10 * c_BAUD;

  typedef struct {
    int         cyc;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_q = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready, o_tx, o_owner, o_collision;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  last_rise = 0;
  ev_t q_acc[$];
  ev_t q_frm[$];
  int  q_col[$];

  servant_uart_tx_arb #(
    .BAUD_DIV  (c_BAUD),
    .IDLE_BITS (c_IDLE)
  ) dut (
    .wb_clk      (clk),
    .wb_rst_n    (rst_n),
    .i_q         (i_q),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_tx        (o_tx),
    .o_owner     (o_owner),
    .o_collision (o_collision)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_q(input logic v);
    if (v && !i_q) last_rise = cyc;
    i_q = v;
  endtask

  // Offer a byte; expected acceptance is the later of now, the idle guard and min_cyc
  task automatic send_byte(input logic [7:0] d, input int min_cyc, input bit keep, output int acc);
    ev_t e;
    bit  got;
    acc = cyc;
    if (last_rise + c_WAIT > acc) acc = last_rise + c_WAIT;
    if (min_cyc > acc) acc = min_cyc;
    e.cyc = acc;
    e.d   = d;
    q_acc.push_back(e);
    e.cyc = acc + 1;
    q_frm.push_back(e);
    i_data  = d;
    i_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    tick();
    if (!keep) i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!o_owner) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
    tick();
  endtask

  // Acceptance monitor
  always @(negedge clk) begin
    if (rst_n && o_ready) begin
      if (q_acc.size() == 0) begin
        check("unexpected_ready", 1, 0);
      end else begin
        ev_t e;
        e = q_acc.pop_front();
        check("accept_cycle", cyc, e.cyc);
        check("accept_data", int'(i_data), int'(e.d));
      end
    end
  end

  // Frame monitor: samples each bit-time, checks hold, content and length
  bit         in_frame = 1'b0;
  int         fstart;
  logic [9:0] fbits;
  bit         fhold;
  logic [7:0] fexp;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else if (o_owner) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        fstart   = cyc;
        fbits    = '0;
        fhold    = 1'b1;
        if (q_frm.size() == 0) begin
          check("unexpected_frame", 1, 0);
          fexp = 8'h00;
        end else begin
          ev_t e;
          e = q_frm.pop_front();
          check("frame_start", cyc, e.cyc);
          fexp = e.d;
        end
      end
      if (cyc - fstart < c_FLEN) begin
        if ((cyc - fstart) % c_BAUD == 0) fbits[(cyc - fstart) / c_BAUD] = o_tx;
        else if (o_tx != fbits[(cyc - fstart) / c_BAUD]) fhold = 1'b0;
      end
    end else if (in_frame) begin
      in_frame = 1'b0;
      check("frame_len", cyc - fstart, c_FLEN);
      check("frame_bits", int'(fbits), int'({1'b1, fexp, 1'b0}));
      check("frame_hold", int'(fhold), 1);
    end
  end

  // Pass-through monitor: outside frames the line is i_q delayed one cycle
  logic prev_q = 1'b1;
  logic prev_rst = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_rst && !o_owner) check("passthru", int'(o_tx), int'(prev_q));
    prev_q   = i_q;
    prev_rst = rst_n;
  end

  // Collision monitor
  always @(negedge clk) begin
    if (rst_n && o_collision) begin
      if (q_col.size() == 0) check("unexpected_collision", 1, 0);
      else check("collision_cycle", cyc, q_col.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, s;
    repeat (3) tick();
    rst_n = 1'b1;
    last_rise = cyc;

    // Reset mid-DATA abandons the frame
    send_byte(8'h3C, 0, 1'b0, a1);
    repeat (8) tick();
    i_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_tx", int'(o_tx), 1);
    check("rst_owner", int'(o_owner), 0);
    check("rst_ready", int'(o_ready), 0);
    tick();
    rst_n = 1'b1;
    last_rise = cyc;
    send_byte(8'h81, 0, 1'b0, a1);
    wait_idle();

    // Pass-through
    set_q(1'b1); tick();
    set_q(1'b0); tick();
    set_q(1'b0); tick();
    set_q(1'b1); tick();

    // Single frame
    send_byte(8'hA5, 0, 1'b0, a1);
    wait_idle();

    // Back-to-back
    send_byte(8'h00, 0, 1'b1, a1);
    send_byte(8'hFF, a1 + c_FLEN + 1, 1'b0, a2);
    wait_idle();

    // Idle guard: valid arrives together with a falling i_q
    i_valid = 1'b1;
    i_data  = 8'h5A;
    for (int p = 0; p < 4; p++) begin
      set_q(1'b0); tick();
      set_q(1'b1);
      repeat (5) tick();
    end
    send_byte(8'h5A, 0, 1'b0, a1);
    wait_idle();

    // Collision mid frame, then pass-through resumes
    send_byte(8'hC3, 0, 1'b0, a1);
    s = a1 + 1;
    while (cyc < s + 12) tick();
    q_col.push_back(s + 13);
    set_q(1'b0);
    repeat (3) tick();
    set_q(1'b1);
    while (cyc < s + c_FLEN) tick();
    set_q(1'b0);
    repeat (2) tick();
    set_q(1'b1);
    repeat (12) tick();

    check("acc_queue_empty", q_acc.size(), 0);
    check("frm_queue_empty", q_frm.size(), 0);
    check("col_queue_empty", q_col.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
